// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_sequencer
// Brief    : Steps a word-wide operand/operation register through a program
//            and executes each captured word on an internal accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module calc_sequencer #(
  parameter int ACC_W     = 8,
  parameter int CNT_W     = 4,
  parameter int MAX_INSTR = 15,
  parameter int TIMEOUT   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             reg_fim,
  input  logic [3:0]       reg_dados,
  input  logic [3:0]       reg_oper,
  output logic             reg_hab,
  output logic             next_word,
  output logic [ACC_W-1:0] acc,
  output logic             carry,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       error_code,
  output logic [CNT_W-1:0] instr_count
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] c_TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(MAX_INSTR);
  localparam logic [3:0]       c_OP_LOAD   = 4'h0;
  localparam logic [3:0]       c_OP_ADD    = 4'h1;
  localparam logic [3:0]       c_OP_SUB    = 4'h2;
  localparam logic [3:0]       c_OP_AND    = 4'h3;
  localparam logic [3:0]       c_OP_OR     = 4'h4;
  localparam logic [3:0]       c_OP_XOR    = 4'h5;
  localparam logic [3:0]       c_OP_HALT   = 4'hF;
  localparam logic [1:0]       c_ERR_NONE  = 2'b00;
  localparam logic [1:0]       c_ERR_ILLOP = 2'b01;
  localparam logic [1:0]       c_ERR_TMO   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENABLE  = 3'd1,
    S_EXEC    = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t           r_state;
  logic             r_hab;
  logic             r_next;
  logic [ACC_W-1:0] r_acc;
  logic             r_carry;
  logic [1:0]       r_err_code;
  logic [CNT_W-1:0] r_cnt;
  logic [TMR_W-1:0] r_timer;
  logic [3:0]       r_oper;
  logic [3:0]       r_dados;

  logic [ACC_W-1:0] w_data;
  logic [ACC_W:0]   w_sum;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_exec_alu;
  logic             w_in_alu;

  assign w_data     = ACC_W'(r_dados);
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_data};
  assign w_cnt_nxt  = r_cnt + CNT_W'(1);
  assign w_exec_alu = (r_oper <= c_OP_XOR);
  // Decoded on the incoming word so next_word lines up with the EXEC cycle.
  assign w_in_alu   = (reg_oper <= c_OP_XOR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_hab      <= 1'b0;
      r_next     <= 1'b0;
      r_acc      <= '0;
      r_carry    <= 1'b0;
      r_err_code <= c_ERR_NONE;
      r_cnt      <= '0;
      r_timer    <= '0;
      r_oper     <= 4'h0;
      r_dados    <= 4'h0;
    end else begin
      r_next <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          r_hab <= 1'b0;
          if (start) begin
            r_state    <= S_ENABLE;
            r_hab      <= 1'b1;
            r_acc      <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_timer    <= '0;
            r_err_code <= c_ERR_NONE;
          end
        end
        S_ENABLE: begin
          if (reg_fim) begin
            r_oper  <= reg_oper;
            r_dados <= reg_dados;
            r_timer <= '0;
            r_hab   <= 1'b0;
            r_next  <= w_in_alu;
            r_state <= S_EXEC;
          end else if (r_timer == c_TMR_LAST) begin
            r_timer    <= '0;
            r_hab      <= 1'b0;
            r_err_code <= c_ERR_TMO;
            r_state    <= S_ERROR;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_EXEC: begin
          r_hab <= 1'b0;
          if (w_exec_alu) begin
            r_cnt   <= w_cnt_nxt;
            r_state <= (w_cnt_nxt == c_CNT_LAST) ? S_DONE : S_RELEASE;
            case (r_oper)
              c_OP_LOAD: begin r_acc <= w_data;          r_carry <= 1'b0; end
              c_OP_ADD:  begin {r_carry, r_acc} <= w_sum; end
              c_OP_SUB:  begin r_acc <= r_acc - w_data;  r_carry <= (r_acc < w_data); end
              c_OP_AND:  begin r_acc <= r_acc & w_data;  r_carry <= 1'b0; end
              c_OP_OR:   begin r_acc <= r_acc | w_data;  r_carry <= 1'b0; end
              default:   begin r_acc <= r_acc ^ w_data;  r_carry <= 1'b0; end
            endcase
          end else if (r_oper == c_OP_HALT) begin
            r_cnt   <= w_cnt_nxt;
            r_state <= S_DONE;
          end else begin
            r_err_code <= c_ERR_ILLOP;
            r_state    <= S_ERROR;
          end
        end
        S_RELEASE: begin
          // The operand register drops its flag a cycle after hab falls.
          if (!reg_fim) begin
            r_hab   <= 1'b1;
            r_state <= S_ENABLE;
          end
        end
        default: begin
          r_hab   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign reg_hab     = r_hab;
  assign next_word   = r_next;
  assign acc         = r_acc;
  assign carry       = r_carry;
  assign error_code  = r_err_code;
  assign instr_count = r_cnt;
  assign busy        = (r_state == S_ENABLE) || (r_state == S_EXEC) || (r_state == S_RELEASE);
  assign done        = (r_state == S_DONE);
  assign error       = (r_state == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_sequencer
// Brief    : Directed bench with an operand-register / word-source model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic fim = 1'b0;
  logic [3:0] oper = 4'h0;
  logic [3:0] dados = 4'h0;

  logic       hab_a, nw_a, carry_a, busy_a, done_a, err_a;
  logic [7:0] acc_a;
  logic [1:0] code_a;
  logic [3:0] cnt_a;
  logic       hab_b, nw_b, carry_b, busy_b, done_b, err_b;
  logic [3:0] acc_b;
  logic [1:0] code_b;
  logic [3:0] cnt_b;

  always #5 clk = ~clk;

  calc_sequencer #(.ACC_W(8), .CNT_W(4), .MAX_INSTR(15), .TIMEOUT(15)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .reg_fim(fim), .reg_dados(dados),
    .reg_oper(oper), .reg_hab(hab_a), .next_word(nw_a), .acc(acc_a),
    .carry(carry_a), .busy(busy_a), .done(done_a), .error(err_a),
    .error_code(code_a), .instr_count(cnt_a));

  calc_sequencer #(.ACC_W(4), .CNT_W(4), .MAX_INSTR(4), .TIMEOUT(15)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .reg_fim(fim), .reg_dados(dados),
    .reg_oper(oper), .reg_hab(hab_b), .next_word(nw_b), .acc(acc_b),
    .carry(carry_b), .busy(busy_b), .done(done_b), .error(err_b),
    .error_code(code_b), .instr_count(cnt_b));

  // The register model serves whichever instance is selected.
  logic       sel = 1'b0;
  logic       hab_m, nw_m, carry_m, busy_m, done_m, err_m;
  logic [7:0] acc_m;
  logic [1:0] code_m;
  logic [3:0] cnt_m;
  assign hab_m   = sel ? hab_b   : hab_a;
  assign nw_m    = sel ? nw_b    : nw_a;
  assign carry_m = sel ? carry_b : carry_a;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign done_m  = sel ? done_b  : done_a;
  assign err_m   = sel ? err_b   : err_a;
  assign acc_m   = sel ? {4'h0, acc_b} : acc_a;
  assign code_m  = sel ? code_b  : code_a;
  assign cnt_m   = sel ? cnt_b   : cnt_a;

  logic [7:0] prog [16];
  logic [7:0] snap_acc [64];
  logic       snap_c [64];
  logic       model_en = 1'b1;
  logic       prev_nw = 1'b0;
  int idx = 0, nw_cnt = 0, nsnap = 0, settle = 0;
  int base_idx = 0, base_nw = 0, base_snap = 0;
  int n_cmp = 0, n_bad = 0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      fim = 1'b0;
      settle = 0;
      prev_nw = 1'b0;
    end else begin
      if (prev_nw) begin
        snap_acc[nsnap % 64] = acc_m;
        snap_c[nsnap % 64] = carry_m;
        nsnap++;
      end
      prev_nw = nw_m;
      if (nw_m) begin
        nw_cnt++;
        idx++;
      end
      if (!hab_m || !model_en) begin
        fim = 1'b0;
        settle = 0;
      end else if (!fim) begin
        settle++;
        if (settle >= 2) begin
          fim = 1'b1;
          {oper, dados} = prog[(idx - base_idx) % 16];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_prog(input logic [31:0] w, input int n, input logic [7:0] fill);
    for (int i = 0; i < 16; i++)
      prog[i] = (i < n) ? w[31-8*i -: 8] : fill;
  endtask

  task automatic kick(input logic which);
    sel = which;
    base_idx = idx;
    base_nw = nw_cnt;
    base_snap = nsnap;
    if (which) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_end();
    int cyc;
    cyc = 0;
    while (!done_m && !err_m && cyc < 500) begin
      tick();
      cyc++;
    end
    if (cyc >= 500) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_end: no done/error within %0d cycles", cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    set_prog(32'hF0F0F0F0, 4, 8'hF0);
    do_reset();
    check("rst_hab", hab_a, 0);
    check("rst_nw", nw_a, 0);
    check("rst_acc", acc_a, 0);
    check("rst_flags", {carry_a, busy_a, done_a, err_a}, 0);
    check("rst_code_cnt", {code_a, cnt_a}, 0);

    set_prog(32'h0513F000, 3, 8'hF0);
    kick(0); wait_end();
    check("t1_acc", acc_m, 8'h08);
    check("t1_carry", carry_m, 0);
    check("t1_cnt", cnt_m, 3);
    check("t1_done_err", {done_m, err_m}, 2'b10);
    check("t1_nw_pulses", nw_cnt - base_nw, 2);

    set_prog(32'h0021F000, 3, 8'hF0);
    kick(0); wait_end();
    check("t2_acc", acc_m, 8'hFF);
    check("t2_carry", carry_m, 1);
    check("t2_done", done_m, 1);

    set_prog(32'h0F1F1FF0, 4, 8'hF0);
    kick(0); wait_end();
    check("t3_add1_acc", snap_acc[(base_snap + 1) % 64], 8'h1E);
    check("t3_add1_c", snap_c[(base_snap + 1) % 64], 0);
    check("t3_add2_acc", snap_acc[(base_snap + 2) % 64], 8'h2D);
    check("t3_add2_c", snap_c[(base_snap + 2) % 64], 0);
    check("t3_cnt", cnt_m, 4);

    set_prog(32'h0F1FF000, 3, 8'hF0);
    kick(1); wait_end();
    check("t3w4_acc", acc_m, 8'h0E);
    check("t3w4_carry", carry_m, 1);

    set_prog(32'h0973F000, 2, 8'hF0);
    kick(0); wait_end();
    check("t4_err", err_m, 1);
    check("t4_code", code_m, 2'b01);
    check("t4_acc", acc_m, 8'h09);
    check("t4_cnt", cnt_m, 1);
    check("t4_hab", hab_m, 0);
    set_prog(32'hF0000000, 1, 8'hF0);
    kick(0);
    check("t4_restart_busy", busy_m, 1);
    check("t4_restart_acc", acc_m, 0);
    check("t4_restart_code", code_m, 0);
    wait_end();

    do_reset();
    model_en = 1'b0;
    kick(0);
    check("t5_hab", hab_m, 1);
    n = 1;
    while (!err_m && n < 100) begin
      tick();
      n++;
    end
    check("t5_enable_cycles", n - 1, 15);
    check("t5_code", code_m, 2'b10);
    check("t5_hab_off", hab_m, 0);
    model_en = 1'b1;

    set_prog(32'h0513F000, 3, 8'hF0);
    kick(0);
    repeat (3) tick();
    check("t5_busy_mid", busy_m, 1);
    start_a = 1'b1;
    repeat (3) tick();
    start_a = 1'b0;
    wait_end();
    check("t5_mid_acc", acc_m, 8'h08);
    check("t5_mid_cnt", cnt_m, 3);

    set_prog(32'h11111111, 4, 8'h11);
    kick(1); wait_end();
    check("t6_done", done_m, 1);
    check("t6_acc", acc_m, 8'h04);
    check("t6_cnt", cnt_m, 4);
    check("t6_nw", nw_cnt - base_nw, 4);

    kick(1);
    n = 0;
    while (!(busy_m && !hab_m && !nw_m) && n < 100) begin
      tick();
      n++;
    end
    check("t6_release_acc", acc_m, 8'h01);
    rst = 1'b1;
    #2;
    check("t6_rst_acc", acc_m, 0);
    check("t6_rst_flags", {hab_m, nw_m, carry_m, done_m, err_m}, 0);
    check("t6_rst_code_cnt", {code_m, cnt_m}, 0);
    check("t6_rst_idle", busy_m, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
